// File: rtl/aes_blk_io.sv
// aes_blk_io: host-side block I/O for an AES-128 core.
// Assembles BUS_W host words into BLK_W key/plaintext blocks. Plaintext is
// queued in an input FIFO for the core. Core results go into an output FIFO
// and are returned to the host one word at a time, most-significant word first.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   wr_en, wr_sel, wr_word           host write (wr_sel 0 = key, 1 = data)
//   in_full, in_count                input FIFO status
//   key_in, key_valid                assembled key to the core
//   data_in, data_valid, data_ready  input FIFO head / core handshake
//   data_out, out_valid, out_ready   core result / output FIFO handshake
//   rd_en, rd_word, rd_valid         host word readback
//   out_count                        output FIFO occupancy
//   err_ovf, err_seq                 sticky error flags
module aes_blk_io #(
    parameter int unsigned BLK_W = 128,
    parameter int unsigned BUS_W = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [BUS_W-1:0]             wr_word,
    output logic                         in_full,
    output logic [BLK_W-1:0]             key_in,
    output logic                         key_valid,
    output logic [BLK_W-1:0]             data_in,
    output logic                         data_valid,
    input  logic                         data_ready,
    input  logic [BLK_W-1:0]             data_out,
    input  logic                         out_valid,
    output logic                         out_ready,
    input  logic                         rd_en,
    output logic [BUS_W-1:0]             rd_word,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   in_count,
    output logic [$clog2(DEPTH+1)-1:0]   out_count,
    output logic                         err_ovf,
    output logic                         err_seq
);

    localparam int unsigned N  = BLK_W / BUS_W;
    localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Assembler state
    logic [BLK_W-1:0] shift_q;
    logic [BW-1:0]    beat_q;
    logic             sel_q;

    // FIFO storage and pointers
    logic [BLK_W-1:0] imem [DEPTH];
    logic [BLK_W-1:0] omem [DEPTH];
    logic [PW-1:0]    ip_wr, ip_rd, op_wr, op_rd;
    logic [BW-1:0]    idx_q;

    // Next-state signals
    logic             mismatch, blk_done, key_done, data_done;
    logic [BLK_W-1:0] shift_base, asm_blk;
    logic [BW-1:0]    beat_base, beat_n;
    logic             in_push, in_pop, drop;
    logic [PW-1:0]    ip_wr_n, ip_rd_n, op_wr_n, op_rd_n;
    logic [CW-1:0]    in_count_n, out_count_n;
    logic [BLK_W-1:0] in_head_n, out_head_n;
    logic             cap, rd_adv, out_pop;
    logic [BW-1:0]    idx_n;
    int unsigned      word_lsb;
    logic [BUS_W-1:0] rd_word_n;

    // Assembler: a sel change mid-block restarts assembly with this word as beat 0
    always_comb begin
        mismatch   = wr_en && (beat_q != '0) && (wr_sel != sel_q);
        shift_base = mismatch ? '0 : shift_q;
        beat_base  = mismatch ? '0 : beat_q;
        asm_blk    = BLK_W'({shift_base, wr_word});
        blk_done   = wr_en && (beat_base == BW'(N - 1));
        beat_n     = blk_done ? '0 : BW'(beat_base + 1'b1);
        key_done   = blk_done && !wr_sel;
        data_done  = blk_done && wr_sel;
    end

    // Input FIFO: a pop in the same cycle frees the slot for a push
    always_comb begin
        in_pop     = data_valid && data_ready;
        in_push    = data_done && (!in_full || in_pop);
        drop       = data_done && !in_push;
        ip_wr_n    = in_push ? PW'(ip_wr + 1'b1) : ip_wr;
        ip_rd_n    = in_pop  ? PW'(ip_rd + 1'b1) : ip_rd;
        in_count_n = CW'(in_count + CW'(in_push) - CW'(in_pop));
        // Only a push into a one-entry result can make the new block the head
        if (in_count_n == '0)
            in_head_n = '0;
        else if (in_push && (ip_rd_n == ip_wr))
            in_head_n = asm_blk;
        else
            in_head_n = imem[ip_rd_n];
    end

    // Output FIFO and disassembler
    always_comb begin
        cap         = out_valid && out_ready;
        rd_adv      = rd_en && rd_valid;
        out_pop     = rd_adv && (idx_q == BW'(N - 1));
        idx_n       = idx_q;
        if (rd_adv)
            idx_n = out_pop ? '0 : BW'(idx_q + 1'b1);
        op_wr_n     = cap     ? PW'(op_wr + 1'b1) : op_wr;
        op_rd_n     = out_pop ? PW'(op_rd + 1'b1) : op_rd;
        out_count_n = CW'(out_count + CW'(cap) - CW'(out_pop));
        if (out_count_n == '0)
            out_head_n = '0;
        else if (cap && (op_rd_n == op_wr))
            out_head_n = data_out;
        else
            out_head_n = omem[op_rd_n];
        word_lsb  = (N - 1 - 32'(idx_n)) * BUS_W;
        rd_word_n = BUS_W'(out_head_n >> word_lsb);
    end

    // FIFO storage, not reset: contents are only visible through the counts
    always_ff @(posedge clk) begin
        if (in_push)
            imem[ip_wr] <= asm_blk;
        if (cap)
            omem[op_wr] <= data_out;
    end

    // Control state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q    <= '0;
            beat_q     <= '0;
            sel_q      <= 1'b0;
            ip_wr      <= '0;
            ip_rd      <= '0;
            op_wr      <= '0;
            op_rd      <= '0;
            idx_q      <= '0;
            key_in     <= '0;
            key_valid  <= 1'b0;
            data_in    <= '0;
            data_valid <= 1'b0;
            in_full    <= 1'b0;
            in_count   <= '0;
            out_count  <= '0;
            out_ready  <= 1'b1;
            rd_word    <= '0;
            rd_valid   <= 1'b0;
            err_ovf    <= 1'b0;
            err_seq    <= 1'b0;
        end else begin
            if (wr_en) begin
                shift_q <= asm_blk;
                beat_q  <= beat_n;
                sel_q   <= wr_sel;
            end
            if (key_done) begin
                key_in    <= asm_blk;
                key_valid <= 1'b1;
            end
            if (mismatch)
                err_seq <= 1'b1;
            if (drop)
                err_ovf <= 1'b1;
            ip_wr      <= ip_wr_n;
            ip_rd      <= ip_rd_n;
            in_count   <= in_count_n;
            in_full    <= (in_count_n == CW'(DEPTH));
            data_in    <= in_head_n;
            data_valid <= (in_count_n != '0);
            op_wr      <= op_wr_n;
            op_rd      <= op_rd_n;
            idx_q      <= idx_n;
            out_count  <= out_count_n;
            out_ready  <= (out_count_n != CW'(DEPTH));
            rd_word    <= rd_word_n;
            rd_valid   <= (out_count_n != '0);
        end
    end

endmodule

// File: tb/tb_aes_blk_io.sv
// Directed self-checking bench for aes_blk_io with default parameters.
module tb_aes_blk_io;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr_en = 1'b0;
    logic         wr_sel = 1'b0;
    logic [31:0]  wr_word = '0;
    logic         in_full;
    logic [127:0] key_in;
    logic         key_valid;
    logic [127:0] data_in;
    logic         data_valid;
    logic         data_ready = 1'b0;
    logic [127:0] data_out = '0;
    logic         out_valid = 1'b0;
    logic         out_ready;
    logic         rd_en = 1'b0;
    logic [31:0]  rd_word;
    logic         rd_valid;
    logic [2:0]   in_count;
    logic [2:0]   out_count;
    logic         err_ovf;
    logic         err_seq;

    int n_cmp = 0;
    int n_err = 0;

    aes_blk_io #(.BLK_W(128), .BUS_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_word(wr_word),
        .in_full(in_full), .key_in(key_in), .key_valid(key_valid),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .rd_en(rd_en), .rd_word(rd_word), .rd_valid(rd_valid),
        .in_count(in_count), .out_count(out_count),
        .err_ovf(err_ovf), .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: called at a negedge, return at the following negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input logic sel, input logic [31:0] w);
        wr_en = 1'b1; wr_sel = sel; wr_word = w;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic block(input logic sel, input logic [127:0] b);
        for (int i = 0; i < 4; i++) beat(sel, b[127-32*i -: 32]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({in_full, key_valid, data_valid, rd_valid, err_ovf, err_seq} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 000000",
                {in_full, key_valid, data_valid, rd_valid, err_ovf, err_seq});
        end
        n_cmp++;
        if (out_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_out_ready got %b want 1", out_ready);
        end
        n_cmp++;
        if ({key_in, data_in, rd_word, in_count, out_count} !== '0) begin
            n_err++; $display("FAIL reset_values key %h data %h rd %h ic %0d oc %0d want all 0",
                key_in, data_in, rd_word, in_count, out_count);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_key_load();
        do_reset();
        beat(0, 32'h2b7e1516); beat(0, 32'h28aed2a6);
        beat(0, 32'habf71588); beat(0, 32'h09cf4f3c);
        n_cmp++;
        if (key_in !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            n_err++; $display("FAIL key_in got %h want 2b7e151628aed2a6abf7158809cf4f3c", key_in);
        end
        n_cmp++;
        if (key_valid !== 1'b1) begin
            n_err++; $display("FAIL key_valid got %b want 1", key_valid);
        end
        n_cmp++;
        if ({err_ovf, err_seq, data_valid} !== 3'b0) begin
            n_err++; $display("FAIL key_side_effects ovf/seq/dv got %b want 000",
                {err_ovf, err_seq, data_valid});
        end
    endtask

    task automatic test_in_overflow();
        do_reset();
        for (int k = 1; k <= 4; k++) block(1, 128'(k));
        n_cmp++;
        if (in_full !== 1'b1 || in_count !== 3'd4) begin
            n_err++; $display("FAIL ovf_full got full %b count %0d want 1 4", in_full, in_count);
        end
        n_cmp++;
        if (err_ovf !== 1'b0) begin
            n_err++; $display("FAIL ovf_early got %b want 0", err_ovf);
        end
        block(1, 128'd5);
        n_cmp++;
        if (err_ovf !== 1'b1 || in_count !== 3'd4) begin
            n_err++; $display("FAIL ovf_drop got ovf %b count %0d want 1 4", err_ovf, in_count);
        end
        data_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (data_valid !== 1'b1 || data_in !== 128'(k)) begin
                n_err++; $display("FAIL ovf_drain[%0d] got dv %b data %h want 1 %0d",
                    k, data_valid, data_in, k);
            end
            tick();
        end
        data_ready = 1'b0;
        n_cmp++;
        if (data_valid !== 1'b0 || data_in !== '0 || in_count !== 3'd0 || in_full !== 1'b0) begin
            n_err++; $display("FAIL ovf_empty got dv %b data %h count %0d full %b want 0 0 0 0",
                data_valid, data_in, in_count, in_full);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int k = 1; k <= 4; k++) block(1, 128'(k));
        beat(1, 32'h0); beat(1, 32'h0); beat(1, 32'h0);
        data_ready = 1'b1;
        beat(1, 32'h5);
        data_ready = 1'b0;
        n_cmp++;
        if (err_ovf !== 1'b0 || in_count !== 3'd4 || in_full !== 1'b1) begin
            n_err++; $display("FAIL fullpop got ovf %b count %0d full %b want 0 4 1",
                err_ovf, in_count, in_full);
        end
        n_cmp++;
        if (data_in !== 128'd2) begin
            n_err++; $display("FAIL fullpop_head got %h want 2", data_in);
        end
        data_ready = 1'b1;
        for (int k = 2; k <= 5; k++) tick();
        data_ready = 1'b0;
        n_cmp++;
        if (data_valid !== 1'b0 || in_count !== 3'd0) begin
            n_err++; $display("FAIL fullpop_drain got dv %b count %0d want 0 0", data_valid, in_count);
        end
    endtask

    task automatic test_readback();
        logic [127:0] res;
        res = 128'h3925841d02dc09fbdc118597196a0b32;
        do_reset();
        out_valid = 1'b1; data_out = res;
        tick();
        out_valid = 1'b0; data_out = '0;
        n_cmp++;
        if (rd_valid !== 1'b1 || out_count !== 3'd1) begin
            n_err++; $display("FAIL rb_valid got %b count %0d want 1 1", rd_valid, out_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_word !== res[127-32*i -: 32]) begin
                n_err++; $display("FAIL rb_word[%0d] got %h want %h", i, rd_word, res[127-32*i -: 32]);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        n_cmp++;
        if (rd_valid !== 1'b0 || out_count !== 3'd0 || rd_word !== 32'h0) begin
            n_err++; $display("FAIL rb_empty got rv %b count %0d word %h want 0 0 0",
                rd_valid, out_count, rd_word);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b0 || out_count !== 3'd0) begin
            n_err++; $display("FAIL rb_idle_read got rv %b count %0d want 0 0", rd_valid, out_count);
        end
    endtask

    task automatic test_out_backpressure();
        logic [127:0] exp_blk;
        do_reset();
        out_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            data_out = {4{32'hb000_0000 + 32'(k)}};
            tick();
            if (k == 4) begin
                n_cmp++;
                if (out_ready !== 1'b0 || out_count !== 3'd4) begin
                    n_err++; $display("FAIL bp_full got ready %b count %0d want 0 4", out_ready, out_count);
                end
            end
        end
        out_valid = 1'b0;
        n_cmp++;
        if (out_count !== 3'd4 || out_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_fifth got count %0d ready %b want 4 0", out_count, out_ready);
        end
        rd_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            exp_blk = {4{32'hb000_0000 + 32'(k)}};
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rd_valid !== 1'b1 || rd_word !== exp_blk[127-32*i -: 32]) begin
                    n_err++; $display("FAIL bp_read[%0d][%0d] got rv %b word %h want 1 %h",
                        k, i, rd_valid, rd_word, exp_blk[127-32*i -: 32]);
                end
                tick();
            end
        end
        rd_en = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b0 || out_count !== 3'd0 || out_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_drained got rv %b count %0d ready %b want 0 0 1",
                rd_valid, out_count, out_ready);
        end
    endtask

    task automatic test_seq_err_reset();
        do_reset();
        beat(1, 32'haaaa0001); beat(1, 32'haaaa0002);
        beat(0, 32'h11111111);
        n_cmp++;
        if (err_seq !== 1'b1 || key_valid !== 1'b0) begin
            n_err++; $display("FAIL seq_flag got seq %b kv %b want 1 0", err_seq, key_valid);
        end
        beat(0, 32'h22222222); beat(0, 32'h33333333); beat(0, 32'h44444444);
        n_cmp++;
        if (key_valid !== 1'b1 || key_in !== 128'h11111111222222223333333344444444) begin
            n_err++; $display("FAIL seq_restart got kv %b key %h want 1 11111111222222223333333344444444",
                key_valid, key_in);
        end
        n_cmp++;
        if (data_valid !== 1'b0 || in_count !== 3'd0) begin
            n_err++; $display("FAIL seq_no_data got dv %b count %0d want 0 0", data_valid, in_count);
        end
        beat(1, 32'hdead0001); beat(1, 32'hdead0002);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({key_valid, err_seq, err_ovf, data_valid, rd_valid, in_full} !== 6'b0 ||
            key_in !== '0 || out_ready !== 1'b1) begin
            n_err++; $display("FAIL midreset got kv %b seq %b key %h ready %b want 0 0 0 1",
                key_valid, err_seq, key_in, out_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        block(1, 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf);
        n_cmp++;
        if (data_valid !== 1'b1 || data_in !== 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf ||
            in_count !== 3'd1 || err_seq !== 1'b0) begin
            n_err++; $display("FAIL postreset_blk got dv %b data %h count %0d seq %b want 1 c0..cf 1 0",
                data_valid, data_in, in_count, err_seq);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        block(0, 128'h000102030405060708090a0b0c0d0e0f);
        block(0, 128'hf0e0d0c0b0a090807060504030201000);
        n_cmp++;
        if (key_in !== 128'hf0e0d0c0b0a090807060504030201000 || key_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_key got %h kv %b want f0e0d0c0b0a090807060504030201000 1",
                key_in, key_valid);
        end
        block(1, 128'haa);
        block(1, 128'hbb);
        n_cmp++;
        if (in_count !== 3'd2 || data_in !== 128'haa || err_seq !== 1'b0) begin
            n_err++; $display("FAIL b2b_data got count %0d data %h seq %b want 2 aa 0",
                in_count, data_in, err_seq);
        end
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        n_cmp++;
        if (in_count !== 3'd1 || data_in !== 128'hbb) begin
            n_err++; $display("FAIL b2b_pop got count %0d data %h want 1 bb", in_count, data_in);
        end
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_in_overflow();
        test_full_pop();
        test_readback();
        test_out_backpressure();
        test_seq_err_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
